// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first WIDTH-bit subtractor (Diff = A - B), one bit per clock via start/done.
// Latency: start sampled at edge N -> done high for one cycle after edge N+WIDTH.
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE (optional Overflow via SERIAL_SUB_OVF_EN).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] work;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             bit_a, bit_b, bit_d, bit_bo;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // A start is only honoured when no operation is in flight.
  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (state == ST_SHIFT) && (cnt == LAST_BIT);

  // One-bit full-subtractor cell on the current LSBs and the registered borrow.
  always_comb begin
    bit_a  = a_sr[0];
    bit_b  = b_sr[0];
    bit_d  = bit_a ^ bit_b ^ brw;
    bit_bo = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: DONE chains straight into SHIFT when start is held.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST_BIT) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded directly from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Operand shift registers, borrow and bit counter; reloaded on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      work <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      work <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == ST_SHIFT) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      work <= {bit_d, work[WIDTH-1:1]};
      brw  <= bit_bo;
      // Counter saturates at the last bit; only a new start clears it.
      if (cnt != LAST_BIT) cnt <= cnt + 1'b1;
    end
  end

  // Published result updates only as the final bit is produced, then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Diff   <= '0;
      Borrow <= 1'b0;
    end else if (last_bit) begin
      Diff   <= {bit_d, work[WIDTH-1:1]};
      Borrow <= bit_bo;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are captured at start because the shift registers lose them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (accept) begin
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
    end
  end

  // Signed overflow: operand signs differ and the result sign differs from the minuend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Overflow <= 1'b0;
    end else if (last_bit) begin
      Overflow <= (a_msb ^ b_msb) & (a_msb ^ bit_d);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8.
// Each scenario task drives stimulus and checks results inline.
// Define SERIAL_SUB_OVF_EN to also cover the Overflow output.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             Overflow;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Diff   (Diff),
    .Borrow (Borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Overflow (Overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge with the given operands, then wait for done (bounded).
  // edges = rising edges from the start edge (counted as 1) to the one that raised done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int edges);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    #12;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (Diff !== 8'h00) begin errors++; $display("FAIL reset_diff got=%h exp=00", Diff); end
    checks++;
    if (Borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", Borrow); end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // 5 - 3 with cycle-accurate busy/done/hold checks.
  task automatic test_basic();
    A = 8'h05;
    B = 8'h03;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_first_shift busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    repeat (WIDTH - 1) tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_last_shift busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    checks++;
    if (Diff !== 8'h00) begin errors++; $display("FAIL basic_hold_during_shift got=%h exp=00", Diff); end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done busy=%b done=%b exp busy=0 done=1", busy, done);
    end
    checks++;
    if (Diff !== 8'h02 || Borrow !== 1'b0) begin
      errors++; $display("FAIL basic_result got=%h/%b exp=02/0", Diff, Borrow);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse busy=%b done=%b exp both 0", busy, done);
    end
    checks++;
    if (Diff !== 8'h02) begin errors++; $display("FAIL basic_hold_idle got=%h exp=02", Diff); end
  endtask

  task automatic test_boundaries();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vd [3];
    logic       vbr[3];
    int edges;
    va[0] = 8'h03; vb[0] = 8'h05; vd[0] = 8'hFE; vbr[0] = 1'b1;
    va[1] = 8'h00; vb[1] = 8'hFF; vd[1] = 8'h01; vbr[1] = 1'b1;
    va[2] = 8'h5A; vb[2] = 8'h5A; vd[2] = 8'h00; vbr[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], edges);
      checks++;
      if (edges !== 9 || done !== 1'b1) begin
        errors++; $display("FAIL bound_latency[%0d] got=%0d edges exp=9", i, edges);
      end
      checks++;
      if (Diff !== vd[i] || Borrow !== vbr[i]) begin
        errors++; $display("FAIL bound_result[%0d] got=%h/%b exp=%h/%b", i, Diff, Borrow, vd[i], vbr[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    A = 8'h10;
    B = 8'h01;
    start = 1'b1;
    edges = 0;
    do begin tick(); edges++; end while (!done && edges < 40);
    checks++;
    if (edges !== 9 || Diff !== 8'h0F) begin
      errors++; $display("FAIL b2b_first got=%0d edges %h exp=9 edges 0F", edges, Diff);
    end
    A = 8'h20;
    B = 8'h02;
    edges = 0;
    do begin tick(); edges++; end while (!done && edges < 40);
    checks++;
    if (edges !== 9 || Diff !== 8'h1E || Borrow !== 1'b0) begin
      errors++; $display("FAIL b2b_second got=%0d edges %h/%b exp=9 edges 1E/0", edges, Diff, Borrow);
    end
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_to_idle busy=%b done=%b exp both 0", busy, done);
    end
  endtask

  task automatic test_ignore_start();
    int edges;
    A = 8'h40;
    B = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    repeat (2) begin tick(); edges++; end
    A = 8'hFF;
    B = 8'h00;
    start = 1'b1;
    tick();
    edges++;
    start = 1'b0;
    while (!done && edges < 40) begin tick(); edges++; end
    checks++;
    if (edges !== 9 || Diff !== 8'h3F || Borrow !== 1'b0) begin
      errors++; $display("FAIL ignore_start got=%0d edges %h/%b exp=9 edges 3F/0", edges, Diff, Borrow);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ignore_no_restart busy=%b done=%b exp both 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_shift();
    int edges;
    A = 8'h03;
    B = 8'h05;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Diff !== 8'h00 || Borrow !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs busy=%b done=%b diff=%h borrow=%b exp all 0",
                         busy, done, Diff, Borrow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle busy=%b exp=0", busy); end
    run_op(8'h81, 8'h02, edges);
    checks++;
    if (edges !== 9 || Diff !== 8'h7F || Borrow !== 1'b0) begin
      errors++; $display("FAIL midrst_recover got=%0d edges %h/%b exp=9 edges 7F/0", edges, Diff, Borrow);
    end
    tick();
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_overflow();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vd [3];
    logic       vo [3];
    int edges;
    va[0] = 8'h80; vb[0] = 8'h01; vd[0] = 8'h7F; vo[0] = 1'b1;
    va[1] = 8'h7F; vb[1] = 8'hFF; vd[1] = 8'h80; vo[1] = 1'b1;
    va[2] = 8'h05; vb[2] = 8'h03; vd[2] = 8'h02; vo[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], edges);
      checks++;
      if (edges !== 9 || Diff !== vd[i] || Overflow !== vo[i]) begin
        errors++; $display("FAIL ovf[%0d] got=%0d edges %h ovf=%b exp=9 edges %h ovf=%b",
                           i, edges, Diff, Overflow, vd[i], vo[i]);
      end
      tick();
    end
  endtask
`endif

  // Coarse grid sweep against a reference subtraction.
  task automatic test_sweep();
    int edges;
    logic [7:0] a, b, exp_d;
    logic       exp_b;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 8'(i * 17 + (j & 1));
        b = 8'(j * 17);
        exp_d = a - b;
        exp_b = (a < b);
        run_op(a, b, edges);
        checks++;
        if (edges !== 9 || Diff !== exp_d || Borrow !== exp_b) begin
          errors++; $display("FAIL sweep a=%h b=%h got=%0d edges %h/%b exp=9 edges %h/%b",
                             a, b, edges, Diff, Borrow, exp_d, exp_b);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (Overflow !== ((a[7] ^ b[7]) & (a[7] ^ exp_d[7]))) begin
          errors++; $display("FAIL sweep_ovf a=%h b=%h got=%b", a, b, Overflow);
        end
`endif
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_shift();
`ifdef SERIAL_SUB_OVF_EN
    test_overflow();
`endif
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
